// File: rtl/fifo_line_ctrl.sv
// Line-buffer FIFO scheduler: per row it clears the write side, fills one row,
// then replays it num_reps times, each replay preceded by a read-pointer clear.
module fifo_line_ctrl #(
  parameter int ADD_WIDTH = 3,
  parameter int FIFO_SIZE = 10,
  parameter int ROW_W     = 8,
  parameter int REP_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADD_WIDTH:0]   row_len,
  input  logic [ROW_W-1:0]     num_rows,
  input  logic [REP_W-1:0]     num_reps,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 wr_clr,
  output logic                 wr_en,
  output logic                 wr_inc,
  output logic                 rd_clr,
  output logic                 rd_en,
  output logic                 rd_inc,
  output logic                 busy,
  output logic                 done,
  output logic [ROW_W-1:0]     row_idx,
  output logic [REP_W-1:0]     rep_idx
);

  localparam int CW = ADD_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, WCLR, FILL, SETTLE, REPLAY, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wcnt, rcnt, eff_len, len_clamped;
  logic [ROW_W-1:0] rows_l;
  logic [REP_W-1:0] reps_l;
  logic            wr_last, rd_last, rep_more, row_more;

  assign len_clamped = (row_len > CW'(FIFO_SIZE)) ? CW'(FIFO_SIZE) : row_len;
  assign wr_last     = (wcnt + CW'(1)) == eff_len;
  assign rd_last     = (rcnt + CW'(1)) == eff_len;
  assign rep_more    = rep_idx < (reps_l - REP_W'(1));
  assign row_more    = row_idx < (rows_l - ROW_W'(1));
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_clr    = 1'b0;
    wr_en     = 1'b0;
    wr_inc    = 1'b0;
    rd_clr    = 1'b0;
    rd_en     = 1'b0;
    rd_inc    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_clamped == '0 || num_rows == '0 || num_reps == '0)
            state_nxt = DONE;
          else
            state_nxt = WCLR;
        end
      end
      WCLR: begin
        wr_clr    = 1'b1;
        state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        wr_en    = in_valid;
        wr_inc   = in_valid;
        if (in_valid && wr_last) state_nxt = SETTLE;
      end
      // One-cycle gap lets the FIFO's registered write land before the first read
      SETTLE: begin
        rd_clr    = 1'b1;
        state_nxt = REPLAY;
      end
      REPLAY: begin
        rd_en  = out_ready;
        rd_inc = out_ready;
        if (out_ready && rd_last) begin
          if (rep_more)      state_nxt = SETTLE;
          else if (row_more) state_nxt = WCLR;
          else               state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      rcnt      <= '0;
      row_idx   <= '0;
      rep_idx   <= '0;
      out_valid <= 1'b0;
      eff_len   <= '0;
      rows_l    <= '0;
      reps_l    <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            eff_len <= len_clamped;
            rows_l  <= num_rows;
            reps_l  <= num_reps;
            row_idx <= '0;
            rep_idx <= '0;
          end
        end
        WCLR:   wcnt <= '0;
        FILL:   if (in_valid) wcnt <= wcnt + CW'(1);
        SETTLE: rcnt <= '0;
        REPLAY: begin
          if (out_ready) begin
            rcnt <= rcnt + CW'(1);
            if (rd_last) begin
              if (rep_more) begin
                rep_idx <= rep_idx + REP_W'(1);
              end else if (row_more) begin
                rep_idx <= '0;
                row_idx <= row_idx + ROW_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_line_ctrl.sv
// Bench for fifo_line_ctrl: table of whole jobs with hand-computed strobe counts,
// plus hand-written reset-abort and replay index sequences.
module tb_fifo_line_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] row_len;
  logic [7:0] num_rows;
  logic [3:0] num_reps;
  logic       in_valid;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic       wr_clr, wr_en, wr_inc;
  logic       rd_clr, rd_en, rd_inc;
  logic       busy, done;
  logic [7:0] row_idx;
  logic [3:0] rep_idx;

  int compared   = 0;
  int mismatched = 0;

  int log_n;
  int log_val [16];

  typedef struct {
    int len, rows, reps;
    int iv_toggle, stall, glitch, chk_idx;
    int e_wclr, e_wen, e_rclr, e_ren, e_ov, e_done, e_cyc;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  fifo_line_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row_len(row_len),
    .num_rows(num_rows), .num_reps(num_reps), .in_valid(in_valid),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .wr_clr(wr_clr), .wr_en(wr_en), .wr_inc(wr_inc), .rd_clr(rd_clr),
    .rd_en(rd_en), .rd_inc(rd_inc), .busy(busy), .done(done),
    .row_idx(row_idx), .rep_idx(rep_idx)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int tag);
    int cyc, n_wclr, n_wen, n_rclr, n_ren, n_ov, n_done;
    int stall_left, pass_wr, viol, lag_err, eff, strobe_err;
    logic prev_rd;
    bit fin;
    eff = (v.len > 10) ? 10 : v.len;
    n_wclr = 0; n_wen = 0; n_rclr = 0; n_ren = 0; n_ov = 0; n_done = 0;
    viol = 0; lag_err = 0; pass_wr = 0; strobe_err = 0;
    stall_left = v.stall ? 3 : 0;
    log_n = 0;
    @(negedge clk);
    row_len  = 4'(v.len);
    num_rows = 8'(v.rows);
    num_reps = 4'(v.reps);
    start    = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; fin = 0; prev_rd = 1'b0;
    while (!fin && cyc < 400) begin
      cyc++;
      in_valid  = v.iv_toggle ? (cyc % 2 == 1) : 1'b1;
      out_ready = !(v.stall != 0 && n_ren == 2 && stall_left > 0);
      if (!out_ready) stall_left--;
      if (v.glitch != 0 && cyc == 3) begin
        start = 1'b1; row_len = 4'd7; num_rows = 8'd2; num_reps = 4'd3;
      end else begin
        start = 1'b0;
      end
      #1;
      if (wr_en !== wr_inc || rd_en !== rd_inc) strobe_err++;
      if ((wr_en && rd_en) || (wr_clr && rd_clr)) viol++;
      if (wr_clr) pass_wr = 0;
      if (wr_en) pass_wr++;
      if (rd_en && pass_wr != eff) viol++;
      if (out_valid !== prev_rd) lag_err++;
      prev_rd = rd_en;
      if (rd_clr && log_n < 16) begin
        log_val[log_n] = int'(row_idx) * 16 + int'(rep_idx);
        log_n++;
      end
      n_wclr += int'(wr_clr);
      n_wen  += int'(wr_en);
      n_rclr += int'(rd_clr);
      n_ren  += int'(rd_en);
      n_ov   += int'(out_valid);
      n_done += int'(done);
      if (done) fin = 1;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    if (!fin) checkOutput($sformatf("v%0d_timeout", tag), 0, 1);
    checkOutput($sformatf("v%0d_wr_clr", tag), n_wclr, v.e_wclr);
    checkOutput($sformatf("v%0d_wr_en", tag),  n_wen,  v.e_wen);
    checkOutput($sformatf("v%0d_rd_clr", tag), n_rclr, v.e_rclr);
    checkOutput($sformatf("v%0d_rd_en", tag),  n_ren,  v.e_ren);
    checkOutput($sformatf("v%0d_out_valid", tag), n_ov, v.e_ov);
    checkOutput($sformatf("v%0d_done", tag),   n_done, v.e_done);
    if (v.e_cyc >= 0) checkOutput($sformatf("v%0d_cycles", tag), cyc, v.e_cyc);
    checkOutput($sformatf("v%0d_excl_order", tag), viol, 0);
    checkOutput($sformatf("v%0d_inc_match", tag), strobe_err, 0);
    checkOutput($sformatf("v%0d_ov_lag", tag), lag_err, 0);
    checkOutput($sformatf("v%0d_busy_after", tag), int'(busy), 0);
    checkOutput($sformatf("v%0d_done_after", tag), int'(done), 0);
  endtask

  initial begin
    int exp_log [6];
    int rd_seen, budget, done_seen;
    logic [9:0] outs;
    // len rows reps tog stall glitch chk | wclr wen rclr ren ov done cyc
    vecs[0] = '{4, 1, 1, 0, 0, 0, 0,  1,  4, 1,  4,  4, 1, 11};
    vecs[1] = '{3, 2, 3, 0, 0, 0, 1,  2,  6, 6, 18, 18, 1, 33};
    vecs[2] = '{5, 1, 2, 1, 1, 0, 0,  1,  5, 2, 10, 10, 1, -1};
    vecs[3] = '{15, 1, 1, 0, 0, 0, 0, 1, 10, 1, 10, 10, 1, 23};
    vecs[4] = '{4, 1, 0, 0, 0, 0, 0,  0,  0, 0,  0,  0, 1,  1};
    vecs[5] = '{0, 3, 2, 0, 0, 0, 0,  0,  0, 0,  0,  0, 1,  1};
    vecs[6] = '{3, 1, 1, 0, 0, 1, 0,  1,  3, 1,  3,  3, 1,  9};
    exp_log = '{0, 1, 2, 16, 17, 18};

    rst_n = 1'b0; start = 1'b0; row_len = '0; num_rows = '0; num_reps = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    #23;
    outs = {in_ready, out_valid, wr_clr, wr_en, wr_inc, rd_clr, rd_en, rd_inc, busy, done};
    checkOutput("reset_outputs", int'(outs), 0);
    checkOutput("reset_row_idx", int'(row_idx), 0);
    checkOutput("reset_rep_idx", int'(rep_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], i);
      if (vecs[i].chk_idx != 0) begin
        checkOutput($sformatf("v%0d_idx_log_len", i), log_n, 6);
        for (int k = 0; k < 6; k++)
          checkOutput($sformatf("v%0d_idx_log%0d", i, k), log_val[k], exp_log[k]);
        checkOutput($sformatf("v%0d_final_row", i), int'(row_idx), 1);
        checkOutput($sformatf("v%0d_final_rep", i), int'(rep_idx), 2);
      end
    end

    // Abort in REPLAY once two reads have gone out
    @(negedge clk);
    row_len = 4'd4; num_rows = 8'd1; num_reps = 4'd1;
    in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_seen = 0; budget = 0;
    while (rd_seen < 2 && budget < 50) begin
      budget++;
      #1;
      rd_seen += int'(rd_en);
      @(negedge clk);
    end
    checkOutput("rst_reach_replay", rd_seen, 2);
    #1;
    checkOutput("rst_pre_busy", int'(busy), 1);
    checkOutput("rst_pre_rd_en", int'(rd_en), 1);
    rst_n = 1'b0;
    #1;
    outs = {in_ready, out_valid, wr_clr, wr_en, wr_inc, rd_clr, rd_en, rd_inc, busy, done};
    checkOutput("rst_mid_outputs", int'(outs), 0);
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      done_seen += int'(done);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      done_seen += int'(done) + int'(busy);
    end
    checkOutput("rst_no_done", done_seen, 0);
    applyStimulus(vecs[0], 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_line_ctrl.md
Name: fifo_line_ctrl

Overview:
- Single-clock scheduler for the line-buffer FIFO in the convolution-transpose path.
- Per output row, it clears the FIFO write side, fills one row of activations, then replays that row NUM_REPS times. Each replay is preceded by a read-pointer clear.
- It drives the FIFO's wr_clr/rd_clr/wr_en/rd_en/wr_inc/rd_inc. It also gives upstream/downstream valid/ready-style flow control and job status.

Parameters:
- ADD_WIDTH, 3, FIFO pointer width minus one; row_len is ADD_WIDTH+1 bits.
- FIFO_SIZE, 10, FIFO depth in entries; row_len above this is clamped.
- ROW_W, 8, width of num_rows and row_idx.
- REP_W, 4, width of num_reps and rep_idx.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- row_len  in  ADD_WIDTH+1  entries per row; latched at start.
- num_rows  in  ROW_W  rows per job; latched at start.
- num_reps  in  REP_W  replays per row; latched at start.
- in_valid  in  1  upstream write data available.
- in_ready  out  1  controller accepting writes (FILL state).
- out_ready  in  1  downstream can take a read.
- out_valid  out  1  FIFO data_out valid this cycle.
- wr_clr  out  1  FIFO write-pointer clear.
- wr_en  out  1  FIFO write enable.
- wr_inc  out  1  FIFO write-pointer increment.
- rd_clr  out  1  FIFO read-pointer/data clear.
- rd_en  out  1  FIFO read enable.
- rd_inc  out  1  FIFO read-pointer increment.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at job end.
- row_idx  out  ROW_W  current row number.
- rep_idx  out  REP_W  current replay number.

Behaviour:
Reset:
- rst_n low forces state IDLE.
- wcnt, rcnt, row_idx, rep_idx, out_valid and the latched config all go to 0.
- All other outputs decode to 0 in IDLE.
- Reset asserted mid-job aborts immediately. No done pulse is produced.

Start:
- In IDLE, start=1 latches eff_len = min(row_len, FIFO_SIZE), num_rows and num_reps.
- If eff_len, num_rows or num_reps is 0, go to DONE. Otherwise go to WCLR.
- start in any other state is ignored.

States (all transitions on the rising clk edge):
- WCLR: wr_clr=1 for exactly 1 cycle; wcnt<=0; next FILL.
- FILL:
  - in_ready=1, wr_en=wr_inc=in_valid.
  - Each in_valid cycle increments wcnt.
  - When the accepted write makes wcnt==eff_len, next SETTLE.
- SETTLE:
  - rd_clr=1 for exactly 1 cycle; rcnt<=0; next REPLAY.
  - Mandatory gap: it absorbs the FIFO's one-cycle registered write-enable latency, so the last write lands before the first read.
- REPLAY:
  - rd_en=rd_inc=out_ready.
  - Each out_ready cycle increments rcnt.
  - When the read makes rcnt==eff_len:
    - if rep_idx<num_reps-1: rep_idx++, next SETTLE;
    - else if row_idx<num_rows-1: rep_idx<=0, row_idx++, next WCLR;
    - else next DONE.
- DONE: done=1 for 1 cycle, busy=1; next IDLE. row_idx/rep_idx hold their final values until the next start.

Output rules:
- in_ready, wr_*, rd_* are combinational from state and in_valid/out_ready.
- Outside their states they are 0.
- wr_en and rd_en are never high in the same cycle. wr_clr and rd_clr are never high together.
- out_valid is rd_en registered: 1-cycle latency, matching the FIFO's registered read data.
- out_valid may be high in the first cycle of SETTLE/WCLR/DONE for the last read.

Arithmetic and boundaries:
- Counters are ADD_WIDTH+1 bits, compared against eff_len. No wrap occurs within a row because eff_len<=FIFO_SIZE.
- row_idx/rep_idx compare against latched values minus one. Zero is excluded at start, so there is no underflow.
- A stall (in_valid=0 or out_ready=0) holds state and counters indefinitely.

Test Plan:
- Basic job: row_len=4, num_rows=1, num_reps=1, in_valid/out_ready tied 1, start.
  - Trace: WCLR 1 cycle, wr_en 4 cycles, rd_clr 1 cycle, rd_en 4 cycles, out_valid 4 cycles lagging rd_en by 1, done pulse, busy low after.
- Replay: row_len=3, num_reps=3, num_rows=2 → exactly 2 wr_clr pulses, 6 wr_en, 6 rd_clr, 18 rd_en.
  - rep_idx sequence per row is 0,1,2.
  - row_idx is 0 then 1.
  - done pulses once.
- Stalls: row_len=5, in_valid toggling 1,0,1,0…, out_ready low 3 cycles mid-replay.
  - Exactly 5 wr_en and 5 rd_en per pass.
  - No rd_en before the SETTLE cycle.
  - Counters hold during stalls.
- Clamp and zero:
  - row_len=15 with FIFO_SIZE=10 → 10 writes and 10 reads per pass.
  - num_reps=0 → start goes straight to DONE: done 1 cycle after start, no FIFO strobes.
- Reset mid-job: assert rst_n=0 during REPLAY with rcnt=2.
  - All outputs go 0 asynchronously; state IDLE; no done pulse.
  - A new start runs a full job correctly.
- Ignored start: pulse start during FILL → latched config is unchanged and the job completes with the original counts.
